// File: rtl/generic_bus_ram_responder.sv
// Word-organised RAM responder for generic_bus_if with a programmable number of
// wait states, out-of-range detection and sticky error flags.
module generic_bus_ram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] OOR_DATA  = 32'hBAD1_BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        oor_err,
    output logic        proto_err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] lat_addr, lat_addr_d;
    logic [31:0] lat_wdata, lat_wdata_d;
    logic [3:0]  lat_be, lat_be_d;
    logic        lat_wr, lat_wr_d;

    logic [31:0] mem [DEPTH];

    // A 33-bit difference makes addresses below BASE_ADDR land above SPAN,
    // so one unsigned compare covers both ends of the window without wrap.
    logic [32:0]   diff, diff_d;
    logic          inr, inr_d;
    logic [AW-1:0] idx, idx_d;

    assign diff   = {1'b0, lat_addr} - {1'b0, BASE_ADDR};
    assign inr    = diff < SPAN;
    assign idx    = diff[AW+1:2];
    assign diff_d = {1'b0, lat_addr_d} - {1'b0, BASE_ADDR};
    assign inr_d  = diff_d < SPAN;
    assign idx_d  = diff_d[AW+1:2];

    assign busy = (state != S_DONE);

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_addr_d  = lat_addr;
        lat_wdata_d = lat_wdata;
        lat_be_d    = lat_be;
        lat_wr_d    = lat_wr;
        case (state)
            S_IDLE: begin
                if (ren || wen) begin
                    lat_addr_d  = addr;
                    lat_wdata_d = wdata;
                    lat_be_d    = byte_en;
                    lat_wr_d    = wen;
                    cnt_d       = 4'(LATENCY);
                    state_d     = (LATENCY == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ren && !wen) begin
                    state_d = S_IDLE;
                end else if (addr != lat_addr || wen != lat_wr) begin
                    lat_addr_d  = addr;
                    lat_wdata_d = wdata;
                    lat_be_d    = byte_en;
                    lat_wr_d    = wen;
                    cnt_d       = 4'(LATENCY);
                end else begin
                    cnt_d = cnt - 4'd1;
                    if (cnt == 4'd1) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            lat_wr    <= 1'b0;
            rdata     <= 32'd0;
            oor_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat_addr  <= lat_addr_d;
            lat_wdata <= lat_wdata_d;
            lat_be    <= lat_be_d;
            lat_wr    <= lat_wr_d;
            if (state != S_DONE && ren && wen) proto_err <= 1'b1;
            if (state == S_DONE && !inr) oor_err <= 1'b1;
            // Read data is fetched on the edge entering DONE so it is stable
            // for the whole completion cycle.
            if (state_d == S_DONE && !lat_wr_d) rdata <= inr_d ? mem[idx_d] : OOR_DATA;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM macros; RST only gates
    // the write so a reset in the DONE cycle commits nothing.
    always_ff @(posedge CLK) begin
        if (!RST && state == S_DONE && lat_wr && inr) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// Bench for generic_bus_ram_responder: a LATENCY=2 instance at base 0 and a
// LATENCY=0 instance at base 0x100, checked against an array-based model.
module tb_generic_bus_ram_responder;

    localparam logic [31:0] B0  = 32'h0000_0000;
    localparam int          D0  = 16;
    localparam int          L0  = 2;
    localparam logic [31:0] B1  = 32'h0000_0100;
    localparam int          D1  = 8;
    localparam int          L1  = 0;
    localparam logic [31:0] OOR = 32'hBAD1_BAD1;

    logic        clk;
    logic        rst0, rst1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ren0, wen0, ren1, wen1;
    logic [3:0]  be0, be1;
    logic [31:0] rdata0, rdata1;
    logic        busy0, busy1, oor0, oor1, proto0, proto1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m0 [D0];
    logic [31:0] m1 [D1];
    bit          oor_m   [2];
    bit          proto_m [2];

    generic_bus_ram_responder #(.BASE_ADDR(B0), .DEPTH(D0), .LATENCY(L0), .OOR_DATA(OOR)) u0 (
        .CLK(clk), .RST(rst0), .addr(addr0), .wdata(wdata0), .ren(ren0), .wen(wen0),
        .byte_en(be0), .rdata(rdata0), .busy(busy0), .oor_err(oor0), .proto_err(proto0));

    generic_bus_ram_responder #(.BASE_ADDR(B1), .DEPTH(D1), .LATENCY(L1), .OOR_DATA(OOR)) u1 (
        .CLK(clk), .RST(rst1), .addr(addr1), .wdata(wdata1), .ren(ren1), .wen(wen1),
        .byte_en(be1), .rdata(rdata1), .busy(busy1), .oor_err(oor1), .proto_err(proto1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint base_of(input int inst);
        return (inst == 0) ? longint'(B0) : longint'(B1);
    endfunction

    function automatic bit in_rng(input int inst, input logic [31:0] a);
        longint span;
        span = 4 * ((inst == 0) ? D0 : D1);
        return longint'(a) >= base_of(inst) && longint'(a) < base_of(inst) + span;
    endfunction

    function automatic int word_of(input int inst, input logic [31:0] a);
        return int'((longint'(a) - base_of(inst)) / 4);
    endfunction

    function automatic logic [31:0] model_rd(input int inst, input logic [31:0] a);
        if (!in_rng(inst, a)) return OOR;
        if (inst == 0) return m0[word_of(inst, a)];
        return m1[word_of(inst, a)];
    endfunction

    task automatic model_wr(input int inst, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] b);
        logic [31:0] w;
        if (in_rng(inst, a)) begin
            w = model_rd(inst, a);
            for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (inst == 0) m0[word_of(inst, a)] = w;
            else           m1[word_of(inst, a)] = w;
        end
    endtask

    // ---------------- bus helpers ----------------
    task automatic drive(input int inst, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b);
        if (inst == 0) begin
            ren0 = r; wen0 = w; addr0 = a; wdata0 = wd; be0 = b;
        end else begin
            ren1 = r; wen1 = w; addr1 = a; wdata1 = wd; be1 = b;
        end
    endtask

    function automatic logic busy_of(input int inst);
        return (inst == 0) ? busy0 : busy1;
    endfunction
    function automatic logic [31:0] rdata_of(input int inst);
        return (inst == 0) ? rdata0 : rdata1;
    endfunction
    function automatic logic oor_of(input int inst);
        return (inst == 0) ? oor0 : oor1;
    endfunction
    function automatic logic proto_of(input int inst);
        return (inst == 0) ? proto0 : proto1;
    endfunction

    // Called just after a rising edge with the DUT idle; returns the cycle
    // (request cycle = 0) in which busy dropped, or -1 on timeout.
    task automatic access(input int inst, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = '0;
        drive(inst, r, w, a, wd, b);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (!busy_of(inst)) begin
                lat = c;
                rd  = rdata_of(inst);
                break;
            end
        end
        drive(inst, 1'b0, 1'b0, a, wd, b);
        @(posedge clk); #1;
    endtask

    task automatic do_op(input int inst, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b, output logic [31:0] rd);
        int          lat;
        int          exp_lat;
        logic [31:0] exp_rd;
        exp_lat = ((inst == 0) ? L0 : L1) + 1;
        exp_rd  = model_rd(inst, a);
        if (r && w) proto_m[inst] = 1'b1;
        access(inst, r, w, a, wd, b, lat, rd);
        check($sformatf("u%0d latency @%h", inst, a), lat, exp_lat);
        if (r && !w) check($sformatf("u%0d rdata @%h", inst, a), rd, exp_rd);
        if (w) model_wr(inst, a, wd, b);
        if (!in_rng(inst, a)) oor_m[inst] = 1'b1;
        check($sformatf("u%0d oor_err", inst), oor_of(inst), oor_m[inst]);
        check($sformatf("u%0d proto_err", inst), proto_of(inst), proto_m[inst]);
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [31:0] rd, rd1, rd2;
        int          done, first, second;
        bit          any_done;
        int          inst;
        int          k;
        logic        r, w;
        logic [31:0] a;

        tbl[0] = '{1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h10, 32'h0,         4'hF, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'hF, 32'h0};
        tbl[3] = '{1'b0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'h5, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 32'h10, 32'h0,         4'hF, 32'h11BB_33DD};
        tbl[5] = '{1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h13, 32'h0,         4'hF, 32'h11BB_33DD};
        tbl[7] = '{1'b1, 1'b0, 32'h40, 32'h0,         4'hF, 32'hBAD1_BAD1};

        rst0 = 1'b1; rst1 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        check("u0 reset busy", busy0, 1);
        check("u0 reset rdata", rdata0, 0);
        check("u0 reset oor_err", oor0, 0);
        check("u0 reset proto_err", proto0, 0);
        check("u1 reset busy", busy1, 1);
        check("u1 reset rdata", rdata1, 0);
        check("u1 reset oor_err", oor1, 0);
        check("u1 reset proto_err", proto1, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < D0; i++) do_op(0, 1'b0, 1'b1, B0 + 32'(4 * i), $urandom, 4'hF, rd);
        for (int i = 0; i < D1; i++) do_op(1, 1'b0, 1'b1, B1 + 32'(4 * i), $urandom, 4'hF, rd);

        // Abort: an out-of-range read dropped in cycle 1 never completes or flags.
        drive(0, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        @(posedge clk); #1;
        any_done = !busy0;
        drive(0, 1'b0, 1'b0, 32'h44, 32'h0, 4'hF);
        repeat (5) begin
            @(posedge clk); #1;
            if (!busy0) any_done = 1'b1;
        end
        check("abort read no completion", any_done, 0);
        check("abort read oor_err", oor0, 0);

        // Abort: a write dropped in cycle 1 leaves the word untouched.
        drive(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        any_done = !busy0;
        drive(0, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        repeat (5) begin
            @(posedge clk); #1;
            if (!busy0) any_done = 1'b1;
        end
        check("abort write no completion", any_done, 0);
        do_op(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd);

        for (int i = 0; i < 8; i++) begin
            do_op(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, rd);
            if (tbl[i].r) check($sformatf("table vec %0d rdata", i), rd, tbl[i].exp);
        end

        // Out-of-range writes must not disturb any word.
        do_op(0, 1'b0, 1'b1, 32'h40, 32'h5A5A_5A5A, 4'hF, rd);
        do_op(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'hF, rd);
        for (int i = 0; i < D0; i++) do_op(0, 1'b1, 1'b0, B0 + 32'(4 * i), 32'h0, 4'hF, rd);
        do_op(1, 1'b0, 1'b1, 32'hFC, 32'h5A5A_5A5A, 4'hF, rd);
        do_op(1, 1'b0, 1'b1, 32'h120, 32'hA5A5_A5A5, 4'hF, rd);
        for (int i = 0; i < D1; i++) do_op(1, 1'b1, 1'b0, B1 + 32'(4 * i), 32'h0, 4'hF, rd);

        // Restart: address changes 0x20 -> 0x24 in cycle 1.
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        @(posedge clk); #1;
        check("restart cycle1 busy", busy0, 1);
        drive(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
        done = -1;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); #1;
            if (!busy0) begin
                done = c;
                rd   = rdata0;
                break;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h24, 32'h0, 4'hF);
        @(posedge clk); #1;
        check("restart completion cycle", done, 4);
        check("restart rdata", rd, model_rd(0, 32'h24));

        // Held request: completions separated by one idle cycle.
        drive(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
        first = -1; second = -1; rd1 = '0; rd2 = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (!busy0) begin
                if (first < 0) begin
                    first = c; rd1 = rdata0;
                end else begin
                    second = c; rd2 = rdata0;
                    break;
                end
            end
        end
        drive(0, 1'b0, 1'b0, 32'h24, 32'h0, 4'hF);
        @(posedge clk); #1;
        check("held first completion", first, 3);
        check("held second completion", second, 7);
        check("held first rdata", rd1, model_rd(0, 32'h24));
        check("held second rdata", rd2, model_rd(0, 32'h24));

        // ren and wen together act as a write and raise proto_err.
        do_op(0, 1'b1, 1'b1, 32'h28, 32'hCAFE_F00D, 4'hF, rd);
        do_op(0, 1'b1, 1'b0, 32'h28, 32'h0, 4'hF, rd);
        check("proto write landed", rd, 32'hCAFE_F00D);

        // Reset in the DONE cycle of a write: nothing commits, state clears.
        drive(0, 1'b0, 1'b1, 32'h8, 32'h0000_0055, 4'hF);
        done = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (!busy0) begin
                done = c;
                break;
            end
        end
        check("reset-in-done write completion", done, 3);
        rst0 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
        @(posedge clk); #1;
        check("mid reset busy", busy0, 1);
        check("mid reset rdata", rdata0, 0);
        check("mid reset oor_err", oor0, 0);
        check("mid reset proto_err", proto0, 0);
        rst0 = 1'b0;
        oor_m[0] = 1'b0; proto_m[0] = 1'b0;
        @(posedge clk); #1;
        do_op(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rd);

        // Randomised traffic on both instances.
        for (int it = 0; it < 120; it++) begin
            inst = it % 2;
            k = int'($urandom_range(0, 9));
            r = (k == 0) || (k >= 5);
            w = (k <= 4);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: a = 32'(base_of(inst) + 4 * ((inst == 0) ? D0 : D1))
                           + 32'($urandom_range(0, 63));
                    1: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                    default: a = (inst == 1) ? B1 - 32'($urandom_range(1, 16))
                                             : B0 + 32'(4 * D0);
                endcase
            end else begin
                a = 32'(base_of(inst)) + 32'($urandom_range(0, 4 * ((inst == 0) ? D0 : D1) - 1));
            end
            do_op(inst, r, w, a, $urandom, 4'($urandom_range(0, 15)), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
